// File: rtl/fft_input_lane_packer_if.sv
// Serial-in / lane-parallel-out bus of the FFT input packer.
// master drives samples and out_ready; slave is the packer.
interface fft_input_lane_packer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 2
);
  logic                        in_valid;
  logic                        in_sop;
  logic                        in_inv;
  logic [DATA_WIDTH-1:0]       in_real;
  logic [DATA_WIDTH-1:0]       in_imag;
  logic                        in_ready;
  logic                        out_valid;
  logic                        out_ready;
  logic                        out_sop;
  logic                        out_eop;
  logic                        out_inv;
  logic [LANES*DATA_WIDTH-1:0] out_real;
  logic [LANES*DATA_WIDTH-1:0] out_imag;
  logic                        frame_err;

  modport master (
    output in_valid, in_sop, in_inv,
    output in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_sop,
    input  out_eop, out_inv, out_real,
    input  out_imag, frame_err
  );

  modport slave (
    input  in_valid, in_sop, in_inv,
    input  in_real, in_imag, out_ready,
    output in_ready, out_valid, out_sop,
    output out_eop, out_inv, out_real,
    output out_imag, frame_err
  );
endinterface

// File: rtl/fft_input_lane_packer.sv
// Packs LANES serial complex samples into one parallel word,
// tracking FFT frame boundaries and aborting on a mid-frame sop.
module fft_input_lane_packer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int LANES      = 2,
  parameter  int FRAME_LEN  = 32768,
  localparam int LANE_BITS  = $clog2(LANES),
  localparam int WORDS      = FRAME_LEN / LANES,
  localparam int WORD_BITS  = (WORDS > 1) ? $clog2(WORDS) : 1
) (
  input logic                      clk_fft,
  input logic                      reset,
  fft_input_lane_packer_if.slave   bus
);

  localparam int DW = DATA_WIDTH;
  localparam int OW = LANES * DATA_WIDTH;
  localparam logic [LANE_BITS-1:0] LAST_LANE = LANE_BITS'(LANES - 1);
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(WORDS - 1);

  typedef enum logic {
    IDLE,
    FILL
  } state_e;

  state_e                  state_q, state_d;
  logic [LANE_BITS-1:0]    lane_q, lane_d;
  logic [WORD_BITS-1:0]    word_q, word_d;
  logic                    inv_q, inv_d;
  logic [LANES-2:0][DW-1:0] re_q, re_d;
  logic [LANES-2:0][DW-1:0] im_q, im_d;

  logic                    out_valid_q, out_valid_d;
  logic                    out_sop_q, out_sop_d;
  logic                    out_eop_q, out_eop_d;
  logic                    out_inv_q, out_inv_d;
  logic [OW-1:0]           out_real_q, out_real_d;
  logic [OW-1:0]           out_imag_q, out_imag_d;
  logic                    frame_err_q, frame_err_d;

  logic                    in_ready;
  logic                    accept;
  logic                    start;
  logic                    fill;
  logic                    last_word;

  assign in_ready  = !out_valid_q || bus.out_ready;
  assign accept    = bus.in_valid && in_ready;
  assign last_word = (word_q == LAST_WORD);

  always_comb begin
    start = 1'b0;
    fill  = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept && bus.in_sop) start = 1'b1;
      end
      FILL: begin
        if (accept) begin
          if (bus.in_sop) begin
            start       = 1'b1;
            frame_err_d = 1'b1;
          end else begin
            fill = 1'b1;
          end
        end
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    word_d      = word_q;
    inv_d       = inv_q;
    re_d        = re_q;
    im_d        = im_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_inv_d   = out_inv_q;
    out_real_d  = out_real_q;
    out_imag_d  = out_imag_q;

    if (out_valid_q && bus.out_ready) out_valid_d = 1'b0;

    // A restart discards any partial word: lane 0 is overwritten.
    if (start) begin
      state_d = FILL;
      inv_d   = bus.in_inv;
      re_d[0] = bus.in_real;
      im_d[0] = bus.in_imag;
      lane_d  = LANE_BITS'(1);
      word_d  = '0;
    end

    if (fill) begin
      if (lane_q == LAST_LANE) begin
        for (int k = 0; k < LANES - 1; k++) begin
          out_real_d[k*DW +: DW] = re_q[k];
          out_imag_d[k*DW +: DW] = im_q[k];
        end
        out_real_d[(LANES-1)*DW +: DW] = bus.in_real;
        out_imag_d[(LANES-1)*DW +: DW] = bus.in_imag;
        out_valid_d = 1'b1;
        out_sop_d   = (word_q == '0);
        out_eop_d   = last_word;
        out_inv_d   = inv_q;
        lane_d      = '0;
        if (last_word) begin
          word_d  = '0;
          state_d = IDLE;
        end else begin
          word_d = word_q + 1'b1;
        end
      end else begin
        for (int k = 0; k < LANES - 1; k++) begin
          if (lane_q == LANE_BITS'(k)) begin
            re_d[k] = bus.in_real;
            im_d[k] = bus.in_imag;
          end
        end
        lane_d = lane_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_fft) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_q      <= '0;
      word_q      <= '0;
      inv_q       <= 1'b0;
      re_q        <= '0;
      im_q        <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_inv_q   <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      inv_q       <= inv_d;
      re_q        <= re_d;
      im_q        <= im_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_inv_q   <= out_inv_d;
      out_real_q  <= out_real_d;
      out_imag_q  <= out_imag_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_eop   = out_eop_q;
  assign bus.out_inv   = out_inv_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_fft_input_lane_packer.sv
// Scoreboard bench for the FFT input lane packer:
// a LANES=2/FRAME_LEN=8 and a LANES=4/FRAME_LEN=16 instance.
module tb_fft_input_lane_packer;

  logic clk_fft = 1'b0;
  logic reset   = 1'b1;

  always #5 clk_fft = ~clk_fft;

  fft_input_lane_packer_if #(.DATA_WIDTH(16), .LANES(2)) a2 ();
  fft_input_lane_packer_if #(.DATA_WIDTH(16), .LANES(4)) a4 ();

  fft_input_lane_packer #(
    .DATA_WIDTH(16), .LANES(2), .FRAME_LEN(8)
  ) u_dut2 (
    .clk_fft (clk_fft),
    .reset   (reset),
    .bus     (a2.slave)
  );

  fft_input_lane_packer #(
    .DATA_WIDTH(16), .LANES(4), .FRAME_LEN(16)
  ) u_dut4 (
    .clk_fft (clk_fft),
    .reset   (reset),
    .bus     (a4.slave)
  );

  typedef struct {
    logic [63:0] re;
    logic [63:0] im;
    logic        sop;
    logic        eop;
    logic        inv;
  } exp_t;

  exp_t q2[$];
  exp_t q4[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ferr2 = 0;
  int   ferr4 = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic exp2(input int a, input int b,
                      input bit s, input bit e, input bit i);
    exp_t x;
    x.re  = {32'h0, b[15:0], a[15:0]};
    x.im  = {32'h0, ~b[15:0], ~a[15:0]};
    x.sop = s;
    x.eop = e;
    x.inv = i;
    q2.push_back(x);
  endtask

  task automatic exp4(input int a, input bit s, input bit e);
    exp_t x;
    int   b = a + 1;
    int   c = a + 2;
    int   d = a + 3;
    x.re  = {d[15:0], c[15:0], b[15:0], a[15:0]};
    x.im  = {~d[15:0], ~c[15:0], ~b[15:0], ~a[15:0]};
    x.sop = s;
    x.eop = e;
    x.inv = 1'b0;
    q4.push_back(x);
  endtask

  task automatic push2(input bit sop, input bit inv, input int r);
    int t = 0;
    a2.in_valid = 1'b1;
    a2.in_sop   = sop;
    a2.in_inv   = inv;
    a2.in_real  = r[15:0];
    a2.in_imag  = ~r[15:0];
    while (!a2.in_ready && t < 100) begin
      @(negedge clk_fft);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout2", 64'(a2.in_ready), 64'd1);
    @(posedge clk_fft);
    #1;
    a2.in_valid = 1'b0;
    a2.in_sop   = 1'b0;
  endtask

  task automatic push4(input bit sop, input int r);
    int t = 0;
    a4.in_valid = 1'b1;
    a4.in_sop   = sop;
    a4.in_inv   = 1'b0;
    a4.in_real  = r[15:0];
    a4.in_imag  = ~r[15:0];
    while (!a4.in_ready && t < 100) begin
      @(negedge clk_fft);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout4", 64'(a4.in_ready), 64'd1);
    @(posedge clk_fft);
    #1;
    a4.in_valid = 1'b0;
    a4.in_sop   = 1'b0;
  endtask

  always @(negedge clk_fft) begin : mon2
    exp_t x;
    if (a2.frame_err) ferr2++;
    if (!reset && a2.out_valid && a2.out_ready) begin
      if (q2.size() == 0) begin
        chk("spurious2", 64'(a2.out_valid), 64'd0);
      end else begin
        x = q2.pop_front();
        chk("re2",  64'(a2.out_real), x.re);
        chk("im2",  64'(a2.out_imag), x.im);
        chk("sop2", 64'(a2.out_sop),  64'(x.sop));
        chk("eop2", 64'(a2.out_eop),  64'(x.eop));
        chk("inv2", 64'(a2.out_inv),  64'(x.inv));
      end
    end
  end

  always @(negedge clk_fft) begin : mon4
    exp_t x;
    if (a4.frame_err) ferr4++;
    if (!reset && a4.out_valid && a4.out_ready) begin
      if (q4.size() == 0) begin
        chk("spurious4", 64'(a4.out_valid), 64'd0);
      end else begin
        x = q4.pop_front();
        chk("re4",  64'(a4.out_real), x.re);
        chk("im4",  64'(a4.out_imag), x.im);
        chk("sop4", 64'(a4.out_sop),  64'(x.sop));
        chk("eop4", 64'(a4.out_eop),  64'(x.eop));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    a2.in_valid = 0; a2.in_sop = 0; a2.in_inv = 0;
    a2.in_real = 0; a2.in_imag = 0; a2.out_ready = 1;
    a4.in_valid = 0; a4.in_sop = 0; a4.in_inv = 0;
    a4.in_real = 0; a4.in_imag = 0; a4.out_ready = 1;

    repeat (3) @(posedge clk_fft);
    #1;
    chk("rst_valid",   64'(a2.out_valid), 64'd0);
    chk("rst_sop",     64'(a2.out_sop),   64'd0);
    chk("rst_eop",     64'(a2.out_eop),   64'd0);
    chk("rst_inv",     64'(a2.out_inv),   64'd0);
    chk("rst_real",    64'(a2.out_real),  64'd0);
    chk("rst_imag",    64'(a2.out_imag),  64'd0);
    chk("rst_ferr",    64'(a2.frame_err), 64'd0);
    chk("rst_ready",   64'(a2.in_ready),  64'd1);
    chk("rst_valid4",  64'(a4.out_valid), 64'd0);
    reset = 1'b0;

    // 1: back-to-back frame, latency check per sample
    for (int w = 0; w < 4; w++)
      exp2(2*w + 1, 2*w + 2, w == 0, w == 3, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      push2(k == 1, 1'b0, k);
      chk("t1_latency", 64'(a2.out_valid), 64'(k % 2 == 0));
    end
    repeat (4) @(negedge clk_fft);
    chk("t1_drain", 64'(q2.size()), 64'd0);

    // 2: backpressure on word 0
    for (int w = 0; w < 4; w++)
      exp2(2*w + 1, 2*w + 2, w == 0, w == 3, 1'b0);
    a2.out_ready = 1'b0;
    fork
      begin : t2_src
        for (int k = 1; k <= 8; k++) push2(k == 1, 1'b0, k);
      end
      begin : t2_sink
        int t;
        t = 0;
        while (!a2.out_valid && t < 50) begin
          @(negedge clk_fft);
          t++;
        end
        if (t >= 50) chk("t2_valid_timeout", 64'(a2.out_valid), 64'd1);
        repeat (5) begin
          @(negedge clk_fft);
          chk("t2_hold_real",  64'(a2.out_real),  64'h0002_0001);
          chk("t2_hold_valid", 64'(a2.out_valid), 64'd1);
          chk("t2_in_ready",   64'(a2.in_ready),  64'd0);
        end
        @(posedge clk_fft);
        #1;
        a2.out_ready = 1'b1;
      end
    join
    repeat (4) @(negedge clk_fft);
    chk("t2_drain", 64'(q2.size()), 64'd0);

    // 3: stray non-sop samples in IDLE
    for (int k = 0; k < 3; k++) push2(1'b0, 1'b0, 50 + k);
    @(negedge clk_fft);
    chk("t3_no_out", 64'(a2.out_valid), 64'd0);
    for (int w = 0; w < 4; w++)
      exp2(60 + 2*w, 61 + 2*w, w == 0, w == 3, 1'b0);
    for (int k = 0; k < 8; k++) push2(k == 0, 1'b0, 60 + k);
    repeat (4) @(negedge clk_fft);
    chk("t3_drain", 64'(q2.size()), 64'd0);

    // 4: mid-frame sop aborts and restarts
    chk("t4_ferr_before", 64'(ferr2), 64'd0);
    exp2(1, 2, 1'b1, 1'b0, 1'b0);
    exp2(3, 4, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < 4; w++)
      exp2(20 + 2*w, 21 + 2*w, w == 0, w == 3, 1'b0);
    for (int k = 1; k <= 5; k++) push2(k == 1, 1'b0, k);
    for (int k = 20; k <= 27; k++) push2(k == 20, 1'b0, k);
    repeat (4) @(negedge clk_fft);
    chk("t4_ferr_pulse", 64'(ferr2), 64'd1);
    chk("t4_drain", 64'(q2.size()), 64'd0);

    // 5: inverse flag latched at sop only
    for (int w = 0; w < 4; w++)
      exp2(30 + 2*w, 31 + 2*w, w == 0, w == 3, 1'b1);
    for (int k = 0; k < 8; k++) push2(k == 0, k % 2 == 0, 30 + k);
    repeat (4) @(negedge clk_fft);
    chk("t5_drain", 64'(q2.size()), 64'd0);

    // 6: LANES=4, reset mid-frame then a clean frame
    exp4(1, 1'b1, 1'b0);
    for (int k = 1; k <= 6; k++) push4(k == 1, k);
    reset = 1'b1;
    @(posedge clk_fft);
    #1;
    chk("t6_rst_valid", 64'(a4.out_valid), 64'd0);
    chk("t6_rst_sop",   64'(a4.out_sop),   64'd0);
    chk("t6_rst_real",  64'(a4.out_real),  64'd0);
    chk("t6_rst_imag",  64'(a4.out_imag),  64'd0);
    chk("t6_rst_ready", 64'(a4.in_ready),  64'd1);
    reset = 1'b0;
    for (int w = 0; w < 4; w++)
      exp4(4*w + 1, w == 0, w == 3);
    for (int k = 1; k <= 16; k++) push4(k == 1, k);
    repeat (4) @(negedge clk_fft);
    chk("t6_drain", 64'(q4.size()), 64'd0);
    chk("t6_ferr",  64'(ferr4), 64'd0);
    chk("final_ferr2", 64'(ferr2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
